// File: rtl/spi_pkg.sv
// spi_pkg: FSM state type and default sizes shared by the SPI burst controller.
package spi_pkg;
  localparam int SLAVES_DEF  = 4;
  localparam int D_WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, ARM, XFER, DONE} state_t;
endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: single-clock FIFO; head shown combinationally (0 when empty), full pushes and empty pops are ignored.
module spi_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: streams cfg_len words from a TX FIFO through a downstream spi_master,
// collecting the returned words in an RX FIFO, with sticky underflow/overflow flags.
module spi_burst_ctrl
  import spi_pkg::*;
#(
  parameter int SLAVES     = SLAVES_DEF,
  parameter int D_WIDTH    = D_WIDTH_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        cfg_addr,
  input  logic [7:0]         cfg_len,
  input  logic [D_WIDTH-1:0] tx_wdata,
  input  logic               tx_wvalid,
  output logic               tx_wready,
  output logic [D_WIDTH-1:0] rx_rdata,
  output logic               rx_rvalid,
  input  logic               rx_rready,
  output logic               active,
  output logic               done,
  output logic               err_udf,
  output logic               err_ovf,
  output logic               spi_enable,
  output logic               spi_cont,
  output logic [31:0]        spi_addr,
  output logic [D_WIDTH-1:0] spi_tx_data,
  input  logic               spi_busy,
  input  logic [D_WIDTH-1:0] spi_rx_data
);
  if (SLAVES < 1 || FIFO_DEPTH < 2) begin : g_bad_cfg
    $error("spi_burst_ctrl: SLAVES must be >=1 and FIFO_DEPTH >=2");
  end
  state_t state;
  logic [7:0] remaining;
  logic busy_q, stop, boundary, tx_pop, rx_push;
  logic tx_full, tx_empty, rx_full, rx_empty;
  // A word ends on the first idle cycle after busy; late busy after enable just delays it.
  assign boundary   = busy_q && !spi_busy;
  assign spi_enable = state == ARM && !tx_empty && !spi_busy;
  assign tx_pop     = spi_enable || (state == XFER && boundary && !stop && remaining > 8'd1);
  assign rx_push    = state == XFER && boundary;
  assign spi_cont   = (state == ARM || state == XFER) && remaining > 8'd1 && !stop;
  assign active     = state != IDLE;
  assign done       = state == DONE;
  assign tx_wready  = !tx_full;
  assign rx_rvalid  = !rx_empty;
  spi_sync_fifo #(.W(D_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_wvalid), .wdata(tx_wdata), .pop(tx_pop),
    .rdata(spi_tx_data), .full(tx_full), .empty(tx_empty)
  );
  spi_sync_fifo #(.W(D_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(spi_rx_data), .pop(rx_rready),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      spi_addr  <= '0;
      err_udf   <= 1'b0;
      err_ovf   <= 1'b0;
      busy_q    <= 1'b0;
      stop      <= 1'b0;
    end else begin
      busy_q <= spi_busy;
      if (state == IDLE && start) begin
        err_udf <= 1'b0;
        err_ovf <= 1'b0;
        stop    <= 1'b0;
        if (cfg_len == 8'd0) state <= DONE;
        else begin
          spi_addr  <= cfg_addr;
          remaining <= cfg_len;
          state     <= ARM;
        end
      end
      if (spi_enable) state <= XFER;
      if (state == XFER && boundary) begin
        remaining <= remaining - 8'd1;
        if (rx_full) err_ovf <= 1'b1;
        // After an underflow the master runs one more word with cont dropped, then we stop.
        if (stop || remaining == 8'd1) state <= DONE;
        else if (tx_empty) begin
          err_udf <= 1'b1;
          stop    <= 1'b1;
        end
      end
      if (state == DONE) state <= IDLE;
    end
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb_spi_burst_ctrl: randomized scenarios against a behavioural spi_master and word-level burst expectations.
module tb_spi_burst_ctrl;
  logic clk = 0, rst = 0, start = 0, tx_wvalid = 0, rx_rready = 0;
  logic [31:0] cfg_addr = 0;
  logic [7:0] cfg_len = 0, tx_wdata = 0, rx_rdata, spi_tx_data, spi_rx_data;
  logic tx_wready, rx_rvalid, active, done, err_udf, err_ovf, spi_enable, spi_cont, spi_busy;
  logic [31:0] spi_addr;
  int errors = 0, checks = 0, done_cnt = 0, en_cnt = 0;
  int m_cnt, m_k;
  logic m_bnd;
  logic [7:0] m_rx;
  logic [7:0] resp_q[$], resp_log[$], tx_log[$], rxq[$], pushed[$];
  logic cont_log[$];

  always #5 clk = ~clk;

  spi_burst_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .tx_wdata(tx_wdata), .tx_wvalid(tx_wvalid), .tx_wready(tx_wready),
    .rx_rdata(rx_rdata), .rx_rvalid(rx_rvalid), .rx_rready(rx_rready),
    .active(active), .done(done), .err_udf(err_udf), .err_ovf(err_ovf),
    .spi_enable(spi_enable), .spi_cont(spi_cont), .spi_addr(spi_addr),
    .spi_tx_data(spi_tx_data), .spi_busy(spi_busy), .spi_rx_data(spi_rx_data)
  );

  // Behavioural spi_master: optional idle cycle, 1-3 busy cycles, response valid at word end.
  assign spi_busy = m_cnt > 0 && m_cnt <= m_k;
  task automatic start_word();
    int k, lat;
    logic [7:0] r;
    k = $urandom_range(1, 3);
    lat = $urandom_range(0, 1);
    r = resp_q.size() > 0 ? resp_q.pop_front() : 8'($urandom);
    m_k <= k;
    m_cnt <= k + lat;
    m_rx <= r;
    resp_log.push_back(r);
    tx_log.push_back(spi_tx_data);
  endtask
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_cnt <= 0; m_k <= 0; m_bnd <= 0; m_rx <= 0; spi_rx_data <= 0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin m_bnd <= 1; spi_rx_data <= m_rx; end
    end else if (m_bnd) begin
      m_bnd <= 0;
      cont_log.push_back(spi_cont);
      if (spi_cont) start_word();
    end else if (spi_enable) start_word();

  always @(posedge clk)
    if (rst) begin
      if (done) done_cnt++;
      if (spi_enable) en_cnt++;
    end

  task automatic clear_logs();
    resp_q.delete(); resp_log.delete(); tx_log.delete(); cont_log.delete(); pushed.delete();
  endtask

  task automatic push_word(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    while (!tx_wready && t < 200) begin @(negedge clk); t++; end
    if (!tx_wready) begin
      checks++; errors++;
      $display("FAIL push_timeout: tx_wready=%b required 1", tx_wready);
    end
    tx_wdata = d; tx_wvalid = 1; pushed.push_back(d);
    @(negedge clk);
    tx_wvalid = 0;
  endtask

  task automatic do_start(input logic [31:0] a, input logic [7:0] l);
    @(negedge clk);
    cfg_addr = a; cfg_len = l; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (active && t < 2000) begin @(negedge clk); t++; end
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL %s_idle_timeout: active=%b required 0", name, active); end
  endtask

  task automatic drain();
    int t = 0;
    rxq.delete();
    @(negedge clk);
    while (rx_rvalid && t < 40) begin
      rxq.push_back(rx_rdata);
      rx_rready = 1;
      @(negedge clk);
      rx_rready = 0;
      t++;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({active, done, spi_enable, spi_cont, err_udf, err_ovf, rx_rvalid, tx_wready} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000001",
               {active, done, spi_enable, spi_cont, err_udf, err_ovf, rx_rvalid, tx_wready});
    end
    checks++;
    if (spi_addr !== 32'd0 || spi_tx_data !== 8'd0 || rx_rdata !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%h tx=%h rx=%h required 0", spi_addr, spi_tx_data, rx_rdata);
    end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_basic();
    int d0 = done_cnt, e0 = en_cnt;
    clear_logs();
    resp_q = '{8'h55, 8'h00};
    push_word(8'h1D); push_word(8'h01);
    do_start(32'd3, 8'd2);
    checks++;
    if (spi_addr !== 32'd3) begin errors++; $display("FAIL basic_addr: got %0d required 3", spi_addr); end
    wait_idle("basic");
    checks++;
    if (en_cnt - e0 !== 1 || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL basic_pulses: enables=%0d dones=%0d required 1 1", en_cnt - e0, done_cnt - d0);
    end
    checks++;
    if (cont_log.size() != 2 || cont_log[0] !== 1'b1 || cont_log[1] !== 1'b0) begin
      errors++; $display("FAIL basic_cont: %0d word ends, cont sequence %p required 1 then 0", cont_log.size(), cont_log);
    end
    checks++;
    if (tx_log.size() != 2 || tx_log[0] !== 8'h1D || tx_log[1] !== 8'h01) begin
      errors++; $display("FAIL basic_tx: got %p required 1d 01", tx_log);
    end
    drain();
    checks++;
    if (rxq.size() != 2 || rxq[0] !== 8'h55 || rxq[1] !== 8'h00) begin
      errors++; $display("FAIL basic_rx: got %p required 55 00", rxq);
    end
    checks++;
    if (err_udf !== 1'b0 || err_ovf !== 1'b0) begin
      errors++; $display("FAIL basic_err: udf=%b ovf=%b required 0 0", err_udf, err_ovf);
    end
  endtask

  task automatic test_zero_len();
    int d0 = done_cnt, e0 = en_cnt;
    @(negedge clk);
    cfg_addr = 32'd2; cfg_len = 8'd0; start = 1;
    @(negedge clk);
    start = 0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done_rise: done=%b required 1", done); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || active !== 1'b0) begin
      errors++; $display("FAIL zero_done_fall: done=%b active=%b required 0 0", done, active);
    end
    checks++;
    if (en_cnt != e0 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL zero_pulses: enables=%0d dones=%0d required 0 1", en_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_underflow();
    int d0 = done_cnt;
    clear_logs();
    push_word(8'hAA);
    do_start(32'd1, 8'd3);
    wait_idle("udf");
    checks++;
    if (err_udf !== 1'b1 || err_ovf !== 1'b0) begin
      errors++; $display("FAIL udf_flags: udf=%b ovf=%b required 1 0", err_udf, err_ovf);
    end
    checks++;
    if (done_cnt - d0 != 1 || tx_log.size() < 1 || tx_log[0] !== 8'hAA) begin
      errors++; $display("FAIL udf_burst: dones=%0d tx=%p required 1 and first word aa", done_cnt - d0, tx_log);
    end
    drain();
    checks++;
    if (rxq.size() != 2 || resp_log.size() != 2 || rxq[0] !== resp_log[0] || rxq[1] !== resp_log[1]) begin
      errors++; $display("FAIL udf_rx: got %p required %p (2 words)", rxq, resp_log);
    end
  endtask

  task automatic test_overflow();
    int bad = 0;
    clear_logs();
    for (int i = 0; i < 8; i++) push_word(8'($urandom));
    do_start(32'd2, 8'd9);
    push_word(8'($urandom));
    wait_idle("ovf");
    checks++;
    if (err_ovf !== 1'b1 || err_udf !== 1'b0) begin
      errors++; $display("FAIL ovf_flags: ovf=%b udf=%b required 1 0", err_ovf, err_udf);
    end
    checks++;
    if (tx_log.size() != 9 || tx_log != pushed) begin
      errors++; $display("FAIL ovf_tx: got %p required %p", tx_log, pushed);
    end
    drain();
    for (int i = 0; i < 8 && i < rxq.size() && i < resp_log.size(); i++) if (rxq[i] !== resp_log[i]) bad++;
    checks++;
    if (rxq.size() != 8 || bad != 0) begin
      errors++; $display("FAIL ovf_rx: got %0d words %p required first 8 of %p", rxq.size(), rxq, resp_log);
    end
  endtask

  task automatic test_reset_mid();
    int d0, t = 0;
    clear_logs();
    for (int i = 0; i < 4; i++) push_word(8'($urandom));
    do_start(32'd0, 8'd4);
    while (resp_log.size() < 2 && t < 500) begin @(negedge clk); t++; end
    checks++;
    if (resp_log.size() < 2) begin errors++; $display("FAIL rstmid_second_word: words=%0d required 2", resp_log.size()); end
    d0 = done_cnt;
    rst = 0;
    #1;
    checks++;
    if (active !== 1'b0 || tx_wready !== 1'b1 || rx_rvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_now: active=%b tx_wready=%b rx_rvalid=%b required 0 1 0", active, tx_wready, rx_rvalid);
    end
    @(negedge clk);
    rst = 1;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != d0 || active !== 1'b0 || spi_tx_data !== 8'd0 || rx_rvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_after: dones=%0d active=%b tx_head=%h rx_rvalid=%b required 0 0 00 0",
                         done_cnt - d0, active, spi_tx_data, rx_rvalid);
    end
  endtask

  task automatic test_ignore_start();
    int d0 = done_cnt;
    clear_logs();
    push_word(8'h11); push_word(8'h22);
    do_start(32'd1, 8'd2);
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL ign_active: active=%b required 1", active); end
    do_start(32'd2, 8'd5);
    checks++;
    if (spi_addr !== 32'd1) begin errors++; $display("FAIL ign_addr: got %0d required 1", spi_addr); end
    wait_idle("ign");
    repeat (5) @(negedge clk);
    checks++;
    if (resp_log.size() != 2 || done_cnt - d0 != 1 || active !== 1'b0) begin
      errors++; $display("FAIL ign_len: words=%0d dones=%0d active=%b required 2 1 0", resp_log.size(), done_cnt - d0, active);
    end
    drain();
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int d0 = done_cnt, e0 = en_cnt;
      logic [7:0] len = 8'($urandom_range(1, 7));
      logic [31:0] a = 32'($urandom_range(0, 3));
      clear_logs();
      for (int i = 0; i < len; i++) push_word(8'($urandom));
      do_start(a, len);
      wait_idle("rand");
      checks++;
      if (tx_log != pushed || spi_addr !== a) begin
        errors++; $display("FAIL rand%0d_tx: got %p addr %0d required %p addr %0d", it, tx_log, spi_addr, pushed, a);
      end
      checks++;
      if (done_cnt - d0 != 1 || en_cnt - e0 != 1 || err_udf !== 1'b0 || err_ovf !== 1'b0) begin
        errors++; $display("FAIL rand%0d_ctl: dones=%0d enables=%0d udf=%b ovf=%b required 1 1 0 0",
                           it, done_cnt - d0, en_cnt - e0, err_udf, err_ovf);
      end
      drain();
      checks++;
      if (rxq != resp_log || rxq.size() != int'(len)) begin
        errors++; $display("FAIL rand%0d_rx: got %p required %p", it, rxq, resp_log);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_underflow();
    test_overflow();
    test_reset_mid();
    test_ignore_start();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
